sr_flag_arbiter: RTL

Round-robin controller that shares a bank of NFLAG SR flip-flops (clock `clk`, per-bit `s`/`r`, output `q`) among NREQ requesters. Each requester asks to set or clear one flag bit. The block serialises the requests and drives single-cycle `s`/`r` pulses into the bank, so `s=r=1` can never reach any bit. After each write it reads the bank's `q` back and flags any mismatch. It sits between the requesting agents and the flag register bank.

---
 rtl/sr_flag_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/sr_flag_arbiter.sv
// Round-robin serialiser of set/clear requests onto a shared SR flag bank.
// Each write is followed by a read-back check of the bank output.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = $clog2(NFLAG)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op_set,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic                 clr_all,
  input  logic [NFLAG-1:0]     q_in,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAG-1:0]     s_out,
  output logic [NFLAG-1:0]     r_out,
  output logic                 busy,
  output logic                 chk_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0]  ONE_REQ  = NREQ'(1);
  localparam logic [NFLAG-1:0] ONE_FLAG = NFLAG'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_BULK,
    ST_CHECK
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ptr;
  logic            r_op;
  logic [IDXW-1:0] r_idx;
  logic            r_bulk;

  logic [2*NREQ-1:0] w_rot;
  logic              w_any;
  logic [PW-1:0]     w_win;
  logic              w_sel_op;
  logic [IDXW-1:0]   w_sel_idx;
  logic              w_sel_oor;
  logic [NFLAG-1:0]  w_sel_mask;
  logic [NFLAG-1:0]  w_chk_mask;
  logic              w_chk_bad;

  // Rotate the request vector so the search always begins at bit 0 = r_ptr.
  always_comb begin
    w_rot = {req, req} >> r_ptr;
    w_any = 1'b0;
    w_win = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!w_any && w_rot[i]) begin
        w_any = 1'b1;
        w_win = PW'((32'(r_ptr) + i) % NREQ);
      end
    end

    w_sel_op  = 1'b0;
    w_sel_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (32'(w_win) == k) begin
        w_sel_op  = op_set[k];
        w_sel_idx = idx[k*IDXW +: IDXW];
      end
    end
    w_sel_oor  = !(32'(w_sel_idx) < NFLAG);
    w_sel_mask = w_sel_oor ? '0 : (ONE_FLAG << w_sel_idx);

    w_chk_mask = ONE_FLAG << r_idx;
    if (r_bulk) begin
      w_chk_bad = |q_in;
    end else if (!(32'(r_idx) < NFLAG)) begin
      w_chk_bad = 1'b1;
    end else begin
      w_chk_bad = ((|(q_in & w_chk_mask)) != r_op);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_op    <= 1'b0;
      r_idx   <= '0;
      r_bulk  <= 1'b0;
      gnt     <= '0;
      s_out   <= '0;
      r_out   <= '0;
      busy    <= 1'b0;
      chk_err <= 1'b0;
    end else begin
      gnt     <= '0;
      s_out   <= '0;
      r_out   <= '0;
      chk_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clr_all) begin
            r_state <= ST_BULK;
            r_bulk  <= 1'b1;
            r_out   <= '1;
            busy    <= 1'b1;
          end else if (w_any) begin
            // Pulses are launched on entry so DRIVE outputs come straight from flops.
            r_state <= ST_DRIVE;
            r_bulk  <= 1'b0;
            r_op    <= w_sel_op;
            r_idx   <= w_sel_idx;
            gnt     <= ONE_REQ << w_win;
            s_out   <= w_sel_op ? w_sel_mask : '0;
            r_out   <= w_sel_op ? '0 : w_sel_mask;
            r_ptr   <= PW'((32'(w_win) + 1) % NREQ);
            busy    <= 1'b1;
          end
        end
        ST_DRIVE, ST_BULK: begin
          r_state <= ST_CHECK;
        end
        ST_CHECK: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          chk_err <= w_chk_bad;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
